ext_mem_arbiter: RTL
====================

Name: ext_mem_arbiter

Overview:
- Shares the single pseudo-2-port external memory between multiple on-chip read requesters and write requesters, e.g. weight fetch, activation fetch and partial-sum writeback.
- Sits inside top_chip, between the compute controllers and the ext_mem_* port group.
- Arbitrates reads and writes independently, round-robin per port.
- Blocks read-after-write address collisions and counts read/write beats for bandwidth reporting.

Parameters:
- ADDR_W, 20, external memory address width (clog2 of EXT_MEM_HEIGHT = 1<<20).
- DATA_W, 32, external memory word width (EXT_MEM_WIDTH).
- N_RD, 3, number of read requesters.
- N_WR, 2, number of write requesters.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rd_req  in  N_RD  per-requester read request.
- rd_addr  in  N_RD*ADDR_W  packed read addresses; requester i occupies slice i.
- rd_gnt  out  N_RD  one-hot read grant.
- rd_rsp_valid  out  N_RD  one-hot read data valid.
- rd_rsp_data  out  DATA_W  read data, shared by all read requesters.
- wr_req  in  N_WR  per-requester write request.
- wr_addr  in  N_WR*ADDR_W  packed write addresses.
- wr_data  in  N_WR*DATA_W  packed write data.
- wr_gnt  out  N_WR  one-hot write grant.
- ext_mem_read_addr  out  ADDR_W  memory read address.
- ext_mem_qout  in  DATA_W  memory read data, valid 1 cycle after the address.
- ext_mem_write_addr  out  ADDR_W  memory write address.
- ext_mem_din  out  DATA_W  memory write data.
- ext_mem_write_en  out  1  memory write strobe.
- clr_counters  in  1  synchronous clear of the statistics counters.
- rd_beats  out  CNT_W  accepted read count.
- wr_beats  out  CNT_W  accepted write count.
- hazard_stalls  out  CNT_W  count of read slots lost to address collisions.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All gnt, rd_rsp_valid and ext_mem_write_en forced 0.
  - Counters = 0.
  - Both round-robin pointers = N-1, so requester 0 has top priority after reset.
  - ext_mem_read_addr, ext_mem_write_addr and ext_mem_din = 0.
- Handshake:
  - A requester raises req with a stable addr (and data) and holds both until it sees gnt.
  - gnt is combinational in the same cycle; each gnt cycle is exactly one beat.
  - Holding req high after gnt gives back-to-back beats.
  - Dropping req without gnt is allowed.
- Arbitration:
  - Separate round-robin for the read port and the write port.
  - Search starts at pointer+1 modulo N; the first asserted req wins.
  - The pointer updates to the winner only on an actual grant.
- Write path:
  - On wr_gnt[j], drive ext_mem_write_en=1, ext_mem_write_addr=wr_addr[j] and ext_mem_din=wr_data[j] in the same cycle.
  - When there is no grant, write_en=0 and addr/din hold their previous values.
- Read path:
  - On rd_gnt[i], drive ext_mem_read_addr=rd_addr[i] in the same cycle; otherwise hold the previous value.
  - A registered tag asserts rd_rsp_valid[i] exactly 1 cycle later with rd_rsp_data=ext_mem_qout.
  - Read latency is 1 cycle; one read is in flight per cycle with full pipelining.
- Collision:
  - If the read winner's addr equals the granted write addr in the same cycle, the write is granted and the read slot stays idle.
  - In that case there is no rd_gnt, the read pointer is unchanged and hazard_stalls increments.
  - The read is then granted next cycle and returns the new data.
- Counters:
  - Increment by 1 per rd_gnt or wr_gnt beat.
  - Saturate at all-ones.
  - clr_counters sets them to 0 and takes precedence over a same-cycle increment.
- Reset mid-operation: an in-flight read response is discarded (rd_rsp_valid=0 next cycle), and arbitration restarts from the reset pointers.
- Requesters with N=1 degenerate to a pass-through with the same timing.

Decomposition:
- Package ext_mem_arb_pkg:
  - Constants EXT_ADDR_W and EXT_DATA_W.
  - typedef ext_addr_t / ext_data_t.
  - Function for saturating increment.
- Sub-module rr_arbiter #(N):
  - Inputs req[N] and an enable that qualifies the grant.
  - Outputs gnt one-hot and a winner index.
  - Contains the pointer register.
  - Instantiated once for reads and once for writes.

Test Plan:
- Read requesters 0, 1, 2 all held high for 6 cycles, distinct addrs -> rd_gnt sequence 0,1,2,0,1,2; each rd_rsp_valid one cycle after its gnt with the matching memory word; rd_beats=6.
- Single write: wr_req[1]=1, addr 0x00010, data 0xDEADBEEF -> same-cycle wr_gnt=2'b10, write_en=1; a later read of 0x00010 returns 0xDEADBEEF; wr_beats=1.
- Collision: write 0x00020 := 0x12345678 and read 0x00020 in the same cycle -> no rd_gnt, hazard_stalls=1; next cycle rd_gnt, then rsp data 0x12345678.
- Reset asserted the cycle after a read grant -> rd_rsp_valid stays 0, counters 0; the next simultaneous req 0 and 1 grants requester 0 first.
- Counter saturation: with CNT_W=4, 20 read beats -> rd_beats=15; clr_counters together with a beat -> 0.
- Idle: no req for 10 cycles -> all gnt, rsp_valid and write_en 0; addresses hold their last values.

Source files
------------

// File: rtl/ext_mem_arb_pkg.sv
// ext_mem_arb_pkg: shared widths, types and counter helper for the external memory arbiter
package ext_mem_arb_pkg;
  localparam int EXT_ADDR_W = 20;
  localparam int EXT_DATA_W = 32;
  typedef logic [EXT_ADDR_W-1:0] ext_addr_t;
  typedef logic [EXT_DATA_W-1:0] ext_data_t;
  // increments v but sticks at the all-ones value of a w-bit counter
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max;
    max = {64{1'b1}} >> (64 - w);
    return (v >= max) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/ext_mem_arbiter_rr.sv
// rr_arbiter: round-robin arbiter, search starts after the last winner, pointer moves only on a grant
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [IW-1:0] r_ptr;
  // descending scan so the smallest offset from the pointer wins
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N; k >= 1; k--)
      if (i_req[(int'(r_ptr) + k) % N]) begin
        o_idx = IW'((int'(r_ptr) + k) % N);
        o_any = 1'b1;
      end
    o_gnt = (i_en && o_any) ? (N'(1) << o_idx) : '0;
  end
  always_ff @(posedge clk)
    if (rst) r_ptr <= IW'(N - 1);
    else if (i_en && o_any) r_ptr <= o_idx;
endmodule

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: shares the pseudo-2-port external memory among read and write requesters,
// with independent round-robin per port, read-after-write collision stalls and beat counters.
module ext_mem_arbiter
  import ext_mem_arb_pkg::*;
#(
  parameter int ADDR_W = EXT_ADDR_W,
  parameter int DATA_W = EXT_DATA_W,
  parameter int N_RD   = 3,
  parameter int N_WR   = 2,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_RD-1:0]     rd_req,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD-1:0]     rd_gnt,
  output logic [N_RD-1:0]     rd_rsp_valid,
  output logic [DATA_W-1:0]   rd_rsp_data,
  input  logic [N_WR-1:0]     wr_req,
  input  logic [N_WR*ADDR_W-1:0] wr_addr,
  input  logic [N_WR*DATA_W-1:0] wr_data,
  output logic [N_WR-1:0]     wr_gnt,
  output logic [ADDR_W-1:0]   ext_mem_read_addr,
  input  logic [DATA_W-1:0]   ext_mem_qout,
  output logic [ADDR_W-1:0]   ext_mem_write_addr,
  output logic [DATA_W-1:0]   ext_mem_din,
  output logic                ext_mem_write_en,
  input  logic                clr_counters,
  output logic [CNT_W-1:0]    rd_beats,
  output logic [CNT_W-1:0]    wr_beats,
  output logic [CNT_W-1:0]    hazard_stalls
);
  localparam int RIW = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int WIW = (N_WR > 1) ? $clog2(N_WR) : 1;
  logic [RIW-1:0]    w_rd_idx;
  logic [WIW-1:0]    w_wr_idx;
  logic              w_rd_any, w_wr_any, w_collide;
  logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [N_RD-1:0]   r_tag;
  logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
  logic [DATA_W-1:0] r_din;
  logic [CNT_W-1:0]  r_rd_beats, r_wr_beats, r_hazard;
  assign w_rd_addr = rd_addr[int'(w_rd_idx)*ADDR_W +: ADDR_W];
  assign w_wr_addr = wr_addr[int'(w_wr_idx)*ADDR_W +: ADDR_W];
  assign w_wr_data = wr_data[int'(w_wr_idx)*DATA_W +: DATA_W];
  // a read that would race a same-cycle write to its address yields the slot to the write
  assign w_collide = !rst && w_rd_any && w_wr_any && (w_rd_addr == w_wr_addr);
  rr_arbiter #(.N(N_RD)) u_rd_arb (
    .clk(clk), .rst(rst), .i_req(rd_req), .i_en(!rst && !w_collide),
    .o_gnt(rd_gnt), .o_idx(w_rd_idx), .o_any(w_rd_any)
  );
  rr_arbiter #(.N(N_WR)) u_wr_arb (
    .clk(clk), .rst(rst), .i_req(wr_req), .i_en(!rst),
    .o_gnt(wr_gnt), .o_idx(w_wr_idx), .o_any(w_wr_any)
  );
  assign ext_mem_write_en   = |wr_gnt;
  assign ext_mem_write_addr = ext_mem_write_en ? w_wr_addr : r_wr_addr;
  assign ext_mem_din        = ext_mem_write_en ? w_wr_data : r_din;
  assign ext_mem_read_addr  = |rd_gnt ? w_rd_addr : r_rd_addr;
  assign rd_rsp_valid       = rst ? '0 : r_tag;
  assign rd_rsp_data        = ext_mem_qout;
  assign rd_beats           = r_rd_beats;
  assign wr_beats           = r_wr_beats;
  assign hazard_stalls      = r_hazard;
  always_ff @(posedge clk)
    if (rst) begin
      r_tag      <= '0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_din      <= '0;
      r_rd_beats <= '0;
      r_wr_beats <= '0;
      r_hazard   <= '0;
    end else begin
      r_tag      <= rd_gnt;
      r_rd_addr  <= ext_mem_read_addr;
      r_wr_addr  <= ext_mem_write_addr;
      r_din      <= ext_mem_din;
      r_rd_beats <= clr_counters ? '0 : |rd_gnt ? CNT_W'(sat_inc(64'(r_rd_beats), CNT_W)) : r_rd_beats;
      r_wr_beats <= clr_counters ? '0 : |wr_gnt ? CNT_W'(sat_inc(64'(r_wr_beats), CNT_W)) : r_wr_beats;
      r_hazard   <= clr_counters ? '0 : w_collide ? CNT_W'(sat_inc(64'(r_hazard), CNT_W)) : r_hazard;
    end
endmodule
